// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared constants and types for the seven-segment display
//               paths: active-low hex glyph table, blank/off codes, default
//               scan timing and the scan slot phase type.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    // Default scan timing: 1 ms digit slot at 100 MHz, 16-cycle anti-ghost gap
    localparam int c_scan_div_dflt    = 100000;
    localparam int c_blank_cyc_dflt   = 16;
    localparam int c_blink_slots_dflt = 256;

    // All segments off (active-low, dp included) and all anodes disabled
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low {g,f,e,d,c,b,a} glyphs for 0..F (dp is appended separately)
    localparam logic [6:0] c_hex_seg7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Phase within a digit slot
    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg7
// Description : Combinational nibble to active-low seven-segment glyph
//               decoder, {g,f,e,d,c,b,a}. Shared by several display paths.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg7
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg7
);

    // Table lookup of the glyph for the incoming nibble
    always_comb begin
        o_seg7 = c_hex_seg7[i_nibble];
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_driver
// Description : Time-multiplexed 4-digit common-anode seven-segment driver.
//               One digit per slot, anti-ghost blank interval at slot start,
//               blink gating, registered anode/segment pins.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int SCAN_DIV    = c_scan_div_dflt,
    parameter int BLANK_CYC   = c_blank_cyc_dflt,
    parameter int BLINK_SLOTS = c_blink_slots_dflt
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp_num,
    input  logic [3:0]  point,
    input  logic [3:0]  blink,
    input  logic        page,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int c_cnt_w  = (SCAN_DIV    > 1) ? $clog2(SCAN_DIV)    : 1;
    localparam int c_slot_w = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

    localparam logic [c_cnt_w-1:0]  c_cnt_last   = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0]  c_blank_end  = c_cnt_w'(BLANK_CYC);
    localparam logic [c_cnt_w-1:0]  c_blank_last = c_cnt_w'(BLANK_CYC - 1);
    localparam logic [c_slot_w-1:0] c_slot_last  = c_slot_w'(BLINK_SLOTS - 1);

    logic [c_cnt_w-1:0]  r_cnt;
    logic [1:0]          r_dig;
    logic [c_slot_w-1:0] r_slot_cnt;
    logic                r_blink_ph;

    scan_state_t         w_state;
    logic                w_wrap;
    logic                w_snap;
    logic                w_gate;
    logic [3:0]          w_nibble;
    logic [6:0]          w_seg7;

    // Slot phase decode and the two edges that change the pins
    always_comb begin
        w_state  = (r_cnt < c_blank_end) ? ST_BLANK : ST_SHOW;
        w_wrap   = (r_cnt == c_cnt_last);
        w_snap   = (w_state == ST_BLANK) && (r_cnt == c_blank_last);
        w_gate   = blink[r_dig] & r_blink_ph;
        w_nibble = disp_num[{page, r_dig, 2'b00} +: 4];
    end

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble (w_nibble),
        .o_seg7   (w_seg7)
    );

    // Slot counter, digit index, blink slot counter and blink phase
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_dig      <= 2'd0;
            r_slot_cnt <= '0;
            r_blink_ph <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_dig <= r_dig + 2'd1;
            if (r_slot_cnt == c_slot_last) begin
                r_slot_cnt <= '0;
                r_blink_ph <= ~r_blink_ph;
            end else begin
                r_slot_cnt <= r_slot_cnt + c_slot_w'(1);
            end
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // Pin registers double as the slot snapshot: loaded once from the inputs
    // at the end of the blank interval and held until the slot wraps
    always_ff @(posedge clk) begin
        if (!rst) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else if (w_wrap) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else if (w_snap) begin
            if (w_gate) begin
                an  <= AN_OFF;
                seg <= SEG_BLANK;
            end else begin
                an  <= ~(4'b0001 << r_dig);
                seg <= {point[r_dig], w_seg7};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_driver
// Description : Self-checking bench for seven_seg_scan_driver. A time-based
//               reference model derives slot, digit and blink phase from the
//               cycle count since reset release and predicts the pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_driver;

    localparam int SCAN_DIV    = 8;
    localparam int BLANK_CYC   = 2;
    localparam int BLINK_SLOTS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] disp_num;
    logic [3:0]  point;
    logic [3:0]  blink;
    logic        page;
    logic [3:0]  an;
    logic [7:0]  seg;

    int          checks = 0;
    int          errors = 0;
    int          t;
    bit          rand_mode;
    logic [7:0]  hex_tab [16];
    logic [3:0]  snap_an;
    logic [7:0]  snap_seg;

    seven_seg_scan_driver #(
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYC   (BLANK_CYC),
        .BLINK_SLOTS (BLINK_SLOTS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .disp_num (disp_num),
        .point    (point),
        .blink    (blink),
        .page     (page),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    task automatic randomize_inputs();
        disp_num = $urandom;
        point    = 4'($urandom);
        blink    = 4'($urandom);
        page     = 1'($urandom);
    endtask

    // Model of what the display should latch for the given slot number,
    // using the inputs as they stand right now
    task automatic record_snapshot(input int slot);
        int         d;
        int         nib;
        bit         gated;
        logic [3:0] one_hot;
        d       = slot % 4;
        nib     = int'(disp_num[(int'(page) * 16 + d * 4) +: 4]);
        gated   = blink[d] && (((slot / BLINK_SLOTS) % 2) == 1);
        one_hot = 4'b0001 << d;
        if (gated) begin
            snap_an  = 4'hF;
            snap_seg = 8'hFF;
        end else begin
            snap_an  = ~one_hot;
            snap_seg = {point[d], hex_tab[nib][6:0]};
        end
    endtask

    // Hold reset for n edges (checking blank pins), then release; t=0 is the
    // period right after the last reset edge
    task automatic apply_reset(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            check_eq("rst_an", 32'(an), 32'h0000_000F);
            check_eq("rst_seg", 32'(seg), 32'h0000_00FF);
        end
        rst = 1'b1;
        t   = 0;
    endtask

    // Run n periods, checking the pins against the model every period
    task automatic run_cycles(input int n);
        int pos;
        int slot;
        for (int k = 0; k < n; k++) begin
            if (rand_mode && ($urandom_range(3) == 0)) randomize_inputs();
            @(negedge clk);
            pos  = t % SCAN_DIV;
            slot = t / SCAN_DIV;
            if (pos < BLANK_CYC) begin
                check_eq("an_blank", 32'(an), 32'h0000_000F);
                check_eq("seg_blank", 32'(seg), 32'h0000_00FF);
            end else begin
                check_eq("an_show", 32'(an), 32'(snap_an));
                check_eq("seg_show", 32'(seg), 32'(snap_seg));
            end
            if (pos == BLANK_CYC - 1) record_snapshot(slot);
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    initial begin
        hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        rand_mode = 1'b0;
        snap_an   = 4'hF;
        snap_seg  = 8'hFF;
        t         = 0;
        rst       = 1'b0;
        disp_num  = 32'h0000_1234;
        point     = 4'hF;
        blink     = 4'h0;
        page      = 1'b0;

        // Reset release and plain scan of 1234 over two refresh periods
        apply_reset(3);
        run_cycles(8 * SCAN_DIV);

        // Upper page with a decimal point on digit 1
        disp_num = 32'hAA55_0000;
        page     = 1'b1;
        point    = 4'b1101;
        apply_reset(1);
        run_cycles(4 * SCAN_DIV);

        // Blink on digit 0 across three blink half-periods
        disp_num = 32'h0;
        page     = 1'b0;
        point    = 4'hF;
        blink    = 4'b0001;
        apply_reset(2);
        run_cycles(12 * SCAN_DIV);

        // Input change mid-slot must not disturb the current slot
        blink    = 4'h0;
        disp_num = 32'h1;
        apply_reset(1);
        run_cycles(4);
        disp_num = 32'h2;
        run_cycles(5 * SCAN_DIV - 4);

        // Reset during digit 2's SHOW window
        disp_num = 32'h0000_1234;
        apply_reset(1);
        run_cycles(2 * SCAN_DIV + 3);
        rst = 1'b0;
        @(posedge clk);
        #2;
        check_eq("rst_mid_an", 32'(an), 32'h0000_000F);
        check_eq("rst_mid_seg", 32'(seg), 32'h0000_00FF);
        rst = 1'b1;
        t   = 0;
        run_cycles(2 * SCAN_DIV);

        // Randomized inputs, changing at random points within slots
        rand_mode = 1'b1;
        for (int r = 0; r < 4; r++) begin
            randomize_inputs();
            apply_reset(int'($urandom_range(3, 1)));
            run_cycles(20 * SCAN_DIV + int'($urandom_range(7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Time-multiplexed driver for the 4-digit common-anode seven-segment display. It consumes the selected display word, decimal-point mask and blink mask produced by the seven-segment display-select stage. It scans one digit per slot with an anti-ghosting blank interval, applies blink gating, and drives the registered anode and segment pins.

## Interface
Parameters:
- SCAN_DIV, 100000 — clk cycles per digit slot (1 ms at 100 MHz); must exceed BLANK_CYC
- BLANK_CYC, 16 — cycles at the start of each slot with all anodes off; ≥1
- BLINK_SLOTS, 256 — slots per blink half-period

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- disp_num  in  32  display word (8 hex nibbles)
- point  in  4  decimal-point mask; point[i]=0 lights DP of digit i
- blink  in  4  blink mask; blink[i]=1 makes digit i blink
- page  in  1  0: show disp_num[15:0]; 1: show disp_num[31:16]
- an  out  4  anode enables, active-low; an[i] drives digit i
- seg  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}

## Operation
- Slot counter cnt runs 0..SCAN_DIV-1 and wraps. The digit index dig (2 bits) advances mod 4 on each wrap.
- Slot slot_cnt runs 0..BLINK_SLOTS-1. On its wrap, blink_ph toggles.
- States: BLANK (cnt < BLANK_CYC) and SHOW (cnt ≥ BLANK_CYC).
- Snapshot: on the edge where cnt goes BLANK_CYC-1 → BLANK_CYC, sample nibble, point[dig], blink[dig] and page into registers. Inputs changing during SHOW do not affect the current slot.
- Nibble for digit i:
  - page=0: disp_num[4i+3:4i]
  - page=1: disp_num[16+4i+3:16+4i]
- Hex decode, active-low: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (shown with dp off, bit7=1). Then seg[7]=point[dig].
- Blink gating: if the sampled blink bit is 1 and blink_ph=1, the whole slot stays blank (an=1111, seg=FF). The counters still advance.
- Reset (rst=0 on a clk edge): cnt=0, dig=0, slot_cnt=0, blink_ph=0, an=4'b1111, seg=8'hFF. Reset mid-slot aborts the slot; the next slot after release is digit 0.

## Timing
- an and seg are registered and update only on clk edges. They never glitch between digits: an returns to 1111 for BLANK_CYC cycles before any anode change.
- After rst deasserts (first edge with rst=1 is cycle 0):
  - Cycles 0..BLANK_CYC-1: blank.
  - First edge at cnt=BLANK_CYC-1: an becomes 1110 with digit 0's pattern, visible from cycle BLANK_CYC.
- Wrap edge (cnt=SCAN_DIV-1): an/seg go blank, dig increments, slot_cnt increments.
- Full refresh period is 4·SCAN_DIV cycles. The blink period is 2·BLINK_SLOTS·SCAN_DIV cycles.
- Input-to-display latency is at most SCAN_DIV+BLANK_CYC cycles.
- Simultaneous slot wrap and blink wrap: blink_ph toggles on the same edge. The next slot's gating uses the new phase.

## Structure
- Shared package seven_seg_pkg holds:
  - the 16-entry active-low hex pattern constant
  - SEG_BLANK=8'hFF and AN_OFF=4'hF
  - the default timing constants
- Combinational sub-module hex_to_seg7 (4-bit nibble in, 7-bit active-low pattern out). It is reused by other display paths.
- The top level holds the counters, the BLANK/SHOW decode, the snapshot registers and the output registers.

## Test plan
Bench parameters: SCAN_DIV=8, BLANK_CYC=2, BLINK_SLOTS=4.
- Reset: hold rst=0 for 3 cycles with disp_num=32'h0000_1234, then release → an=1111/seg=FF for cycles 0–1; cycles 2–7 an=1110 seg=99.
- Scan: page=0, disp_num=32'h0000_1234, point=4'hF → successive SHOW windows (an/seg) 1110/99, 1101/B0, 1011/A4, 0111/F9, then repeat; 2 blank cycles between each.
- Page and point: disp_num=32'hAA55_0000, page=1, point=4'b1101 → digit0 92, digit1 12 (DP lit), digit2 88, digit3 88.
- Blink: blink=4'b0001, disp_num=32'h0 → slots 0–3 digit0 shows C0. In slots 4–7, digit0's slot stays an=1111 while digits 1–3 still show C0. Digit0 shows C0 again in slots 8–11.
- Mid-slot change: change disp_num from 32'h1 to 32'h2 at cnt=4 of digit0's slot → seg stays F9 until the wrap; the next digit0 slot shows A4.
- Reset mid-slot: assert rst=0 during digit2's SHOW → an=1111/seg=FF on the next edge; after release, digit 0 is the first digit shown, at cycle 2.
